// File: rtl/dmem_arbiter_32.sv
// dmem_arbiter_32: two-requester arbiter/sequencer in front of the 64-word data memory.
// Requester 0 is the core LSU, requester 1 the DMA/debug port. Each request runs
// accept -> ACCESS -> RESP. Alignment and range are checked before the memory is touched.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on contention;
// without it requester 0 has fixed priority.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no transaction in flight; a valid request is accepted here
// ACCESS | latched request drives the memory for exactly one cycle
// RESP   | owner's rsp valid pulse; a new request may be accepted here too
module dmem_arbiter_32 #(
  parameter int NUM_WORDS = 64,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] mem_addr_32,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata_32,
  input  logic [DATA_W-1:0] mem_rdata_32
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q;
  logic                owner_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                grant0, grant1;
  logic                accept_ok;
  logic                accept;
  logic                addr_err;

  // Pick a winner among the asserted valids; contention policy is the build option.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_RR_EN
      if (last_grant_q) grant0 = 1'b1;
      else              grant1 = 1'b1;
`else
      grant0 = 1'b1;
`endif
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

`ifndef DMEM_ARB_RR_EN
  // Fixed priority keeps last_grant tracked but never consults it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // Accepts happen in IDLE or RESP only, never while reset is asserted.
  assign accept_ok  = (state_q != ACCESS) && !areset;
  assign req0_ready = accept_ok && grant0;
  assign req1_ready = accept_ok && grant1;
  assign accept     = req0_ready || req1_ready;

  // Word index must be inside the memory and the byte address word-aligned.
  assign addr_err = (addr_q[1:0] != 2'b00) ||
                    ({2'b00, addr_q[ADDR_W-1:2]} >= ADDR_W'(NUM_WORDS));

  // Next-state and memory-port drive; the memory bus is quiet outside ACCESS.
  always_comb begin
    state_d      = state_q;
    mem_addr_32  = '0;
    mem_wdata_32 = '0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = accept ? ACCESS : IDLE;
      end
      ACCESS: begin
        state_d      = RESP;
        mem_addr_32  = addr_q;
        mem_wdata_32 = wdata_q;
        // areset here must block the write on this very edge
        mem_we       = we_q && !addr_err && !areset;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Latch the accepted request and remember who won.
  always_ff @(posedge clk) begin
    if (areset) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else if (accept) begin
      last_grant_q <= req1_ready;
      owner_q      <= req1_ready;
      we_q         <= req1_ready ? req1_we    : req0_we;
      addr_q       <= req1_ready ? req1_addr  : req0_addr;
      wdata_q      <= req1_ready ? req1_wdata : req0_wdata;
    end
  end

  // Capture the access result into the owner's response registers; pulse valid in RESP.
  always_ff @(posedge clk) begin
    if (areset) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= (state_q == ACCESS) && !owner_q;
      rsp1_valid <= (state_q == ACCESS) &&  owner_q;
      if (state_q == ACCESS) begin
        if (owner_q) begin
          rsp1_rdata <= (we_q || addr_err) ? '0 : mem_rdata_32;
          rsp1_err   <= addr_err;
        end else begin
          rsp0_rdata <= (we_q || addr_err) ? '0 : mem_rdata_32;
          rsp0_err   <= addr_err;
        end
      end
    end
  end

endmodule
